// File: rtl/fifo_pkg.sv
// Shared types for the FIFO write-side logic: arbiter state encoding and
// the burst counter width helper.
package fifo_pkg;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_round_robin_pick.sv
// Combinational round-robin picker: scans req starting just after 'last',
// wrapping around, and returns the first set bit as a one-hot pick.
module round_robin_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the FIFO write port with a bounded burst per grant;
// writes are gated by the FIFO Full flag.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          CLK_w,
  input  logic                          RST_w,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_in,
  input  logic                          Full,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [NUM_REQ-1:0]            Ack,
  output logic                          EN_w,
  output logic [DATA_WIDTH-1:0]         W_data,
  output logic                          Busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   pick;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic                 owner_req;
  logic                 en_w;
  logic                 rel;

  // last_q always holds the current owner while granted, so one picker
  // serves both the idle arbitration and the release re-arbitration.
  round_robin_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (Req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  always_comb begin
    owner_req = |(Req & grant_q);
    en_w      = (state_q == ST_GRANT) && owner_req && !Full;
    rel       = (state_q == ST_GRANT) &&
                ((en_w && (cnt_q == CNT_W'(MAX_BURST - 1))) || !owner_req);
    W_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) W_data = Data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign EN_w  = en_w;
  assign Ack   = grant_q & {NUM_REQ{en_w}};
  assign Grant = grant_q;
  assign Busy  = (state_q == ST_GRANT);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          grant_d = pick;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          cnt_d = '0;
          if (pick_valid) begin
            grant_d = pick;
            last_d  = pick_idx;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (en_w) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_w or posedge RST_w) begin
    if (RST_w) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter: a per-cycle ownership model
// predicts writes into a scoreboard that a separate monitor drains.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] data_in;
  logic          full;
  logic [N-1:0]  grant;
  logic [N-1:0]  ack;
  logic          en_w;
  logic [DW-1:0] w_data;
  logic          busy;

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .CLK_w   (clk),
    .RST_w   (rst),
    .Req     (req),
    .Data_in (data_in),
    .Full    (full),
    .Grant   (grant),
    .Ack     (ack),
    .EN_w    (en_w),
    .W_data  (w_data),
    .Busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          who;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sbq[$];
  wr_t exp_wr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who owns the port, who was granted last, words this grant.
  int owner = -1;
  int last  = N - 1;
  int words = 0;
  int acked = -1;
  int seq[N];

  function automatic logic [DW-1:0] word_of(input int i, input int s);
    return DW'((i << 6) | (s & 63));
  endfunction

  function automatic int next_after(input int from, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask, input int p_raise,
                               input int p_drop, input int p_full);
    if (acked >= 0) seq[acked]++;
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) req[i] = 1'b0;
      else if (!req[i]) begin
        if ($urandom_range(99) < p_raise) req[i] = 1'b1;
      end else if ($urandom_range(99) < p_drop) req[i] = 1'b0;
      data_in[i*DW +: DW] = word_of(i, seq[i]);
    end
    full = ($urandom_range(99) < p_full);
  endtask

  // Evaluate one cycle of the model against the settled inputs, then advance
  // it to what the coming clock edge should produce.
  task automatic modelCycle();
    bit wr;
    checkOutput("grant", 32'(grant), (owner < 0) ? 32'd0 : 32'(1 << owner));
    checkOutput("busy", 32'(busy), 32'(owner >= 0));
    if (owner >= 0) checkOutput("wdata_owner", 32'(w_data), 32'(data_in[owner*DW +: DW]));
    else            checkOutput("wdata_idle", 32'(w_data), 32'd0);
    wr = (owner >= 0) && req[owner] && !full;
    acked = -1;
    if (wr) begin
      sbq.push_back('{owner, word_of(owner, seq[owner])});
      acked = owner;
      words++;
    end
    if (owner < 0) begin
      if (req != '0) begin
        owner = next_after(last, req);
        last  = owner;
        words = 0;
      end
    end else if ((wr && words == MB) || !req[owner]) begin
      words = 0;
      if (req != '0) begin
        owner = next_after(owner, req);
        last  = owner;
      end else begin
        owner = -1;
      end
    end
  endtask

  task automatic runPhase(input logic [N-1:0] mask, input int p_raise,
                          input int p_drop, input int p_full, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      applyStimulus(mask, p_raise, p_drop, p_full);
      #1;
      modelCycle();
    end
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock.
  task automatic midReset(input logic [N-1:0] new_req);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_en_w", 32'(en_w), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    if (acked >= 0) seq[acked]++;
    acked = -1;
    owner = -1;
    last  = N - 1;
    words = 0;
    sbq.delete();
    req = new_req;
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = word_of(i, seq[i]);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    checkOutput("en_w", 32'(en_w), 32'(sbq.size() != 0));
    if (en_w && sbq.size() != 0) begin
      exp_wr = sbq.pop_front();
      checkOutput("wdata_written", 32'(w_data), 32'(exp_wr.data));
      checkOutput("ack", 32'(ack), 32'(1 << exp_wr.who));
    end else if (!en_w) begin
      checkOutput("ack_quiet", 32'(ack), 32'd0);
      sbq.delete();
    end
  end

  initial begin
    rst     = 1'b1;
    req     = '0;
    full    = 1'b0;
    data_in = '0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    #3;
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_en_w", 32'(en_w), 32'd0);
    checkOutput("reset_wdata", 32'(w_data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    runPhase(4'b0100, 100, 0, 0, 12);
    runPhase(4'b1111, 100, 0, 0, 40);
    runPhase(4'b1111, 100, 0, 30, 60);
    runPhase(4'b1111, 60, 20, 20, 120);
    runPhase(4'b1001, 80, 30, 0, 40);
    runPhase(4'b0100, 100, 0, 0, 5);
    midReset(4'b1100);
    runPhase(4'b1100, 100, 0, 0, 20);
    runPhase(4'b1111, 100, 0, 100, 20);
    runPhase(4'b1111, 50, 15, 25, 200);
    runPhase(4'b0000, 0, 0, 0, 3);

    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
